// File: rtl/redmule_mesh_fixture_pkg.sv
// Shared types and constants for the mesh test fixture: FSM states and exit-code widths.
// Pure declarations; no logic, latency or flow control.
package redmule_mesh_fixture_pkg;

    localparam int EXIT_W = 8;
    localparam logic [EXIT_W-1:0] TIMEOUT_EXIT_CODE = 8'hFF;

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        READY,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/redmule_mesh_eoc_collector.sv
// Per-tile sticky exit-code capture: the first enabled eoc wins; a forced timeout code applies otherwise.
// Result registered one cycle after capture; no backpressure, the capture is held until reset.
module redmule_mesh_eoc_collector
    import redmule_mesh_fixture_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              eoc_i,
    input  logic [EXIT_W-1:0] exit_i,
    input  logic              force_i,
    output logic              capture_o,
    output logic              captured_o,
    output logic [EXIT_W-1:0] exit_o
);

    logic              r_captured;
    logic [EXIT_W-1:0] r_exit;
    logic              w_capture;
    logic              w_force;

    assign w_capture = en_i & eoc_i & ~r_captured;
    // A real eoc arriving in the timeout cycle still reports the tile's own code.
    assign w_force   = force_i & ~r_captured & ~w_capture;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_captured <= 1'b0;
            r_exit     <= '0;
        end else if (w_capture) begin
            r_captured <= 1'b1;
            r_exit     <= exit_i;
        end else if (w_force) begin
            r_captured <= 1'b1;
            r_exit     <= TIMEOUT_EXIT_CODE;
        end
    end

    assign capture_o  = w_capture;
    assign captured_o = r_captured;
    assign exit_o     = r_exit;

endmodule

// File: rtl/redmule_mesh_fixture.sv
// Mesh fixture: tile reset hold, boot-address latch, run/fetch control, sticky eoc/exit collection.
// Outputs register one cycle after their trigger; no backpressure. REDMULE_MESH_TIMEOUT_EN adds a RUN watchdog.
module redmule_mesh_fixture
    import redmule_mesh_fixture_pkg::*;
#(
    parameter int N_TILES        = 4,
    parameter int RST_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [31:0]                boot_addr_i,
    input  logic                       init_i,
    input  logic                       run_i,
    input  logic [N_TILES-1:0]         tile_eoc_i,
    input  logic [N_TILES*EXIT_W-1:0]  tile_exit_i,
    output logic                       reset_done_o,
    output logic [N_TILES-1:0]         tile_rst_no,
    output logic [31:0]                tile_boot_addr_o,
    output logic [N_TILES-1:0]         tile_fetch_en_o,
    output logic                       eoc_o,
    output logic [N_TILES*EXIT_W-1:0]  exit_code_o
);

    localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

    state_e               r_state;
    state_e               w_next;
    logic [RST_CNT_W-1:0] r_rst_cnt;
    logic [31:0]          r_boot_addr;
    logic [N_TILES-1:0]   r_fetch_en;
    logic [N_TILES-1:0]   w_capture;
    logic [N_TILES-1:0]   w_captured;
    logic                 w_run;
    logic                 w_all_done;
    logic                 w_timeout;

    assign w_run      = (r_state == RUN);
    assign w_all_done = &(w_captured | w_capture);

`ifdef REDMULE_MESH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_run_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run_cnt <= '0;
        end else if (w_run) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end else begin
            r_run_cnt <= '0;
        end
    end

    assign w_timeout = w_run && (r_run_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            RST_WAIT: if (r_rst_cnt == RST_LAST) w_next = IDLE;
            IDLE:     if (init_i) w_next = READY;
            READY:    if (run_i) w_next = RUN;
            RUN:      if (w_all_done || w_timeout) w_next = DONE;
            DONE:     w_next = DONE;
            default:  w_next = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= RST_WAIT;
            r_rst_cnt   <= '0;
            r_boot_addr <= '0;
            r_fetch_en  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == RST_WAIT) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
            // Address latch and run start share an edge, so a combined pulse boots from the new address.
            if (init_i && (r_state == IDLE || r_state == READY)) begin
                r_boot_addr <= boot_addr_i;
            end
            if (r_state == READY && run_i) begin
                r_fetch_en <= '1;
            end else if (w_run) begin
                r_fetch_en <= w_timeout ? '0 : (r_fetch_en & ~w_capture);
            end
        end
    end

    for (genvar g = 0; g < N_TILES; g++) begin : g_tile
        redmule_mesh_eoc_collector u_collector (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .en_i       (w_run),
            .eoc_i      (tile_eoc_i[g]),
            .exit_i     (tile_exit_i[g*EXIT_W +: EXIT_W]),
            .force_i    (w_timeout),
            .capture_o  (w_capture[g]),
            .captured_o (w_captured[g]),
            .exit_o     (exit_code_o[g*EXIT_W +: EXIT_W])
        );
    end

    assign reset_done_o     = (r_state != RST_WAIT);
    assign tile_rst_no      = {N_TILES{reset_done_o}};
    assign tile_boot_addr_o = r_boot_addr;
    assign tile_fetch_en_o  = r_fetch_en;
    assign eoc_o            = (r_state == DONE);

endmodule

// File: tb/tb_redmule_mesh_fixture.sv
// Directed bench for redmule_mesh_fixture: reset sequencing, boot/run control, sticky capture, abort and watchdog.
module tb_redmule_mesh_fixture;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] boot_addr_i;
    logic        init_i;
    logic        run_i;
    logic [3:0]  tile_eoc_i;
    logic [31:0] tile_exit_i;
    logic        reset_done_o;
    logic [3:0]  tile_rst_no;
    logic [31:0] tile_boot_addr_o;
    logic [3:0]  tile_fetch_en_o;
    logic        eoc_o;
    logic [31:0] exit_code_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    redmule_mesh_fixture #(
        .N_TILES        (4),
        .RST_CYCLES     (10),
        .TIMEOUT_CYCLES (50)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .boot_addr_i      (boot_addr_i),
        .init_i           (init_i),
        .run_i            (run_i),
        .tile_eoc_i       (tile_eoc_i),
        .tile_exit_i      (tile_exit_i),
        .reset_done_o     (reset_done_o),
        .tile_rst_no      (tile_rst_no),
        .tile_boot_addr_o (tile_boot_addr_o),
        .tile_fetch_en_o  (tile_fetch_en_o),
        .eoc_o            (eoc_o),
        .exit_code_o      (exit_code_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Holds reset, checks cleared outputs, releases and checks the 10-cycle tile reset hold.
    task automatic reset_sequence(input string tag);
        rst_ni = 1'b0;
        #2;
        chk({tag, "_rst_done"},  64'(reset_done_o),     64'h0);
        chk({tag, "_rst_tiles"}, 64'(tile_rst_no),      64'h0);
        chk({tag, "_rst_fetch"}, 64'(tile_fetch_en_o),  64'h0);
        chk({tag, "_rst_eoc"},   64'(eoc_o),            64'h0);
        chk({tag, "_rst_exit"},  64'(exit_code_o),      64'h0);
        chk({tag, "_rst_boot"},  64'(tile_boot_addr_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_i  = 1'b1;
        repeat (9) tick();
        run_i = 1'b0;
        chk({tag, "_done_at_9"},  64'(reset_done_o),    64'h0);
        chk({tag, "_fetch_at_9"}, 64'(tile_fetch_en_o), 64'h0);
        tick();
        chk({tag, "_done_at_10"},  64'(reset_done_o), 64'h1);
        chk({tag, "_tiles_at_10"}, 64'(tile_rst_no),  64'hF);
    endtask

    task automatic boot_and_run(input logic [31:0] addr);
        init_i = 1'b1; boot_addr_i = addr;
        tick();
        init_i = 1'b0; run_i = 1'b1;
        tick();
        run_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; boot_addr_i = '0; init_i = 1'b0; run_i = 1'b0;
        tile_eoc_i = '0; tile_exit_i = '0;

        reset_sequence("por");

        // IDLE: run without init and stray eoc are ignored
        run_i = 1'b1; tile_eoc_i = 4'hF; tile_exit_i = 32'h1122_3344;
        tick(); tick();
        run_i = 1'b0;
        chk("idle_run_fetch", 64'(tile_fetch_en_o), 64'h0);
        chk("idle_eoc_exit",  64'(exit_code_o),     64'h0);
        chk("idle_eoc_flag",  64'(eoc_o),           64'h0);
        tile_eoc_i = '0; tile_exit_i = '0;
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        chk("idle_run2_fetch", 64'(tile_fetch_en_o), 64'h0);

        // READY with an old address, then init+run together picks the new one
        init_i = 1'b1; boot_addr_i = 32'h1111_0000;
        tick();
        chk("ready_boot1",  64'(tile_boot_addr_o), 64'h1111_0000);
        chk("ready_fetch0", 64'(tile_fetch_en_o),  64'h0);
        boot_addr_i = 32'hCC00_0880; run_i = 1'b1;
        tick();
        init_i = 1'b0; run_i = 1'b0; boot_addr_i = '0;
        chk("run_boot",  64'(tile_boot_addr_o), 64'hCC00_0880);
        chk("run_fetch", 64'(tile_fetch_en_o),  64'hF);

        // Tiles finish at cycles 5, 9, 9, 20; tile 1 code changes to 0x55 after capture
        for (int c = 1; c <= 22; c++) begin
            tile_eoc_i[0] = (c >= 5);
            tile_eoc_i[1] = (c >= 9);
            tile_eoc_i[2] = (c >= 9);
            tile_eoc_i[3] = (c >= 20);
            tile_exit_i   = {8'h04, 8'h03, (c >= 10) ? 8'h55 : 8'h02, 8'h01};
            tick();
            if (c == 4)  chk("fetch_c4",  64'(tile_fetch_en_o), 64'hF);
            if (c == 5)  chk("fetch_c5",  64'(tile_fetch_en_o), 64'hE);
            if (c == 9)  chk("fetch_c9",  64'(tile_fetch_en_o), 64'h8);
            if (c == 12) chk("sticky_b1", 64'(exit_code_o[15:8]), 64'h02);
            if (c == 19) chk("eoc_c19",   64'(eoc_o),           64'h0);
            if (c == 20) begin
                chk("eoc_c20",   64'(eoc_o),           64'h1);
                chk("exit_c20",  64'(exit_code_o),     64'h0403_0201);
                chk("fetch_c20", 64'(tile_fetch_en_o), 64'h0);
            end
        end

        // DONE ignores init/run and input changes
        init_i = 1'b1; run_i = 1'b1; boot_addr_i = 32'hDEAD_BEEF; tile_exit_i = 32'h9999_9999;
        tick(); tick();
        init_i = 1'b0; run_i = 1'b0;
        chk("done_boot",  64'(tile_boot_addr_o), 64'hCC00_0880);
        chk("done_fetch", 64'(tile_fetch_en_o),  64'h0);
        chk("done_eoc",   64'(eoc_o),            64'h1);
        chk("done_exit",  64'(exit_code_o),      64'h0403_0201);
        tile_eoc_i = '0; tile_exit_i = '0;

        // Reset mid-RUN after one capture discards it immediately
        reset_sequence("r2");
        boot_and_run(32'h0000_1000);
        tile_eoc_i = 4'h1; tile_exit_i = 32'h0000_00AA;
        tick();
        chk("abort_pre_exit", 64'(exit_code_o), 64'hAA);
        tile_eoc_i = '0; tile_exit_i = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("abort_exit",  64'(exit_code_o),     64'h0);
        chk("abort_fetch", 64'(tile_fetch_en_o), 64'h0);
        chk("abort_done",  64'(reset_done_o),    64'h0);
        reset_sequence("r3");

        // Tile 2 never finishes; others report 0x00
        boot_and_run(32'h0000_2000);
        tile_eoc_i = 4'b1011; tile_exit_i = 32'h0000_0000;
        repeat (60) tick();
`ifdef REDMULE_MESH_TIMEOUT_EN
        chk("to_exit",  64'(exit_code_o),     64'h00FF_0000);
        chk("to_eoc",   64'(eoc_o),           64'h1);
        chk("to_fetch", 64'(tile_fetch_en_o), 64'h0);
`else
        chk("noto_exit",  64'(exit_code_o),     64'h0);
        chk("noto_eoc",   64'(eoc_o),           64'h0);
        chk("noto_fetch", 64'(tile_fetch_en_o), 64'h4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
